mem_stage_access_unit: RTL and testbench
========================================

Name: mem_stage_access_unit

Overview:
- Consumes the EX/MEM pipeline-register outputs and performs the data-memory access for the MEM stage.
- Issues load/store requests to the data memory over a req/ready handshake, with 64-bit and byte transfers.
- Stalls the upstream pipeline until each access completes, then delivers results to the WB stage through its own registered outputs.
- Non-memory instructions pass through with one-cycle latency, as a plain pipeline register.

Parameters:
- TIMEOUT, 16, max cycles in BUSY without mem_ready before the access is aborted with a fault (range 2..255).
- ADDR_W, 64, width of address and data paths.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-low; resets when 0 at a rising clk edge
- address_MEM  input  ADDR_W  ALU result (effective address, or result for non-memory ops)
- Rd2_Reg_out_MEM  input  64  store data
- MemRead_MEM  input  1  load
- MemWrite_MEM  input  1  store
- ByteOp_MEM  input  1  1 = byte access (LDURB/STURB), 0 = doubleword
- RegWrite_MEM  input  1  control passed to WB
- MemtoReg_MEM  input  1  control passed to WB
- Rd_MEM  input  5  destination register
- mem_req  output  1  request valid (registered)
- mem_we  output  1  1 = write
- mem_addr  output  ADDR_W  doubleword-aligned address: address with [2:0] cleared
- mem_wdata  output  64  write data, byte-lane placed
- mem_be  output  8  byte enables
- mem_ready  input  1  memory completes the request this cycle
- mem_rdata  input  64  read data, valid when mem_ready=1
- stall_MEM  output  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- fault_MEM  output  1  one-cycle pulse: misaligned access or timeout
- RegWrite_WB, MemtoReg_WB  output  1  registered controls to WB
- Rd_WB  output  5  registered destination register
- read_data_WB  output  64  registered load result
- alu_result_WB  output  ADDR_W  registered address_MEM

Behaviour:
- Reset (reset=0 at an edge):
  - State IDLE; timeout counter 0.
  - Every registered output is 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, fault_MEM, all *_WB.
  - Reset during BUSY drops mem_req at that edge. Any late mem_ready is ignored.
- Definitions:
  - access = MemRead_MEM | MemWrite_MEM.
  - If both MemRead_MEM and MemWrite_MEM are 1, the access is a write.
  - misaligned = !ByteOp_MEM & (address_MEM[2:0] != 0).
- IDLE, access=0:
  - At the edge, *_WB load from the *_MEM inputs; read_data_WB = 0.
  - stall_MEM=0.
- IDLE, access=1, misaligned:
  - No request is issued. fault_MEM=1 for the next cycle.
  - *_WB load with RegWrite_WB forced to 0. stall_MEM=0.
- IDLE, access=1, aligned:
  - stall_MEM=1 in this cycle.
  - Capture mem_addr, mem_we, mem_wdata, mem_be, the controls and Rd.
  - mem_req=1 from the next cycle. Go to BUSY; counter=0.
  - *_WB load a bubble (RegWrite_WB=0, other *_WB hold their previous values).
- Byte lanes:
  - Doubleword access: mem_be=8'hFF, mem_wdata=Rd2_Reg_out_MEM.
  - Byte access, k=address_MEM[2:0]: mem_be=1<<k; mem_wdata = Rd2[7:0] replicated into all 8 lanes.
  - Byte load: read_data_WB = zero-extended mem_rdata[8k+7:8k].
- BUSY, mem_ready=0:
  - stall_MEM=1; counter increments; mem_req and the request signals stay stable.
  - *_WB hold with RegWrite_WB=0.
- BUSY, mem_ready=1:
  - stall_MEM=0 in the same cycle.
  - At the edge: *_WB load the captured instruction; read_data_WB = extracted rdata (0 for stores).
  - mem_req=0; go to IDLE.
  - The next instruction is then presented on the *_MEM inputs, so back-to-back accesses cost 2 cycles each minimum.
- BUSY, counter reaches TIMEOUT-1 with mem_ready=0:
  - Abort: mem_req=0, go to IDLE, fault_MEM pulse.
  - *_WB load with RegWrite_WB=0. stall_MEM=0 in that cycle.
- mem_req never drops without either mem_ready or a timeout.
- Only one request is outstanding at any time.

Test Plan:
- Reset held 0 for 3 cycles with MemRead_MEM=1 -> mem_req=0, stall_MEM=0, all *_WB=0; after release, the first access request is issued one cycle later.
- Non-memory op: address_MEM=64'h2A, RegWrite_MEM=1, Rd_MEM=5 -> next cycle alu_result_WB=64'h2A, Rd_WB=5, RegWrite_WB=1, stall_MEM never asserted.
- Doubleword load at 64'h100, mem_ready after 3 BUSY cycles with rdata=64'hDEADBEEF_CAFEF00D:
  - mem_addr=64'h100, mem_be=FF.
  - stall_MEM high for 4 cycles.
  - read_data_WB=64'hDEADBEEF_CAFEF00D with RegWrite_WB=1.
- Byte store at 64'h103, Rd2=64'h..A5, then byte load at 64'h106 with rdata[55:48]=8'h7E:
  - Store: mem_be=8'h08, mem_we=1, mem_addr=64'h100.
  - Load: read_data_WB=64'h7E.
- Misaligned doubleword load at 64'h104 -> no mem_req, fault_MEM=1 for one cycle, RegWrite_WB=0.
- Timeout: TIMEOUT=4, store with mem_ready held 0 -> mem_req drops after 4 BUSY cycles, fault_MEM pulses, stall_MEM=0 in that cycle.
- Reset asserted mid-BUSY -> mem_req=0 at that edge; a mem_ready pulse one cycle later produces no *_WB update.

Source files
------------

// File: rtl/mem_stage_access_unit.sv
// MEM-stage data-memory access unit.
//
// Takes the EX/MEM pipeline-register outputs and performs the data-memory
// access over a req/ready handshake. Doubleword and byte transfers are
// supported. The upstream pipeline is stalled while an access is
// outstanding. Results reach the WB stage through registered outputs.
// Non-memory instructions pass through with one cycle of latency.
//
// Ports:
//   clk, reset            rising-edge clock; synchronous active-low reset
//   address_MEM           effective address, or ALU result for non-memory ops
//   Rd2_Reg_out_MEM       store data
//   MemRead_MEM           load
//   MemWrite_MEM          store (a store wins if both read and write are set)
//   ByteOp_MEM            1 = byte access, 0 = doubleword access
//   RegWrite_MEM          write-back control, forwarded to WB
//   MemtoReg_MEM          write-back control, forwarded to WB
//   Rd_MEM                destination register, forwarded to WB
//   mem_req/we/addr/wdata/be   registered request to the data memory
//   mem_ready, mem_rdata  completion and read data from the data memory
//   stall_MEM             combinational freeze of the upstream stages
//   fault_MEM             one-cycle pulse on misaligned access or timeout
//   *_WB                  registered results for the write-back stage
module mem_stage_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_MEM,
  input  logic [63:0]       Rd2_Reg_out_MEM,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic              ByteOp_MEM,
  input  logic              RegWrite_MEM,
  input  logic              MemtoReg_MEM,
  input  logic [4:0]        Rd_MEM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_be,
  input  logic              mem_ready,
  input  logic [63:0]       mem_rdata,
  output logic              stall_MEM,
  output logic              fault_MEM,
  output logic              RegWrite_WB,
  output logic              MemtoReg_WB,
  output logic [4:0]        Rd_WB,
  output logic [63:0]       read_data_WB,
  output logic [ADDR_W-1:0] alu_result_WB
);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  // Last BUSY cycle count that may still wait for mem_ready.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;

  logic       access;
  logic       misaligned;
  logic [2:0] lane;

  // Decoded events for the current cycle.
  logic issue;     // aligned access accepted in IDLE
  logic bad;       // misaligned access rejected in IDLE
  logic complete;  // memory answered in BUSY
  logic abort;     // timeout expired in BUSY

  // Instruction held while its access is outstanding.
  logic              cap_regwrite_reg;
  logic              cap_memtoreg_reg;
  logic              cap_write_reg;
  logic              cap_byte_reg;
  logic [2:0]        cap_lane_reg;
  logic [4:0]        cap_rd_reg;
  logic [ADDR_W-1:0] cap_alu_reg;

  logic [63:0] wdata_byte;
  logic [7:0]  rdata_lanes [8];
  logic [63:0] read_ext;

  assign access     = MemRead_MEM | MemWrite_MEM;
  assign misaligned = !ByteOp_MEM && (address_MEM[2:0] != 3'b000);
  assign lane       = address_MEM[2:0];

  // Byte stores are copied into every lane. mem_be selects the lane that
  // is written. Byte loads pick their lane out of the returned doubleword.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign wdata_byte[8*gi +: 8] = Rd2_Reg_out_MEM[7:0];
      assign rdata_lanes[gi]       = mem_rdata[8*gi +: 8];
    end
  endgenerate

  assign read_ext = cap_byte_reg ? {56'b0, rdata_lanes[cap_lane_reg]} : mem_rdata;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_MEM  = 1'b0;
    issue      = 1'b0;
    bad        = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            bad = 1'b1;
          end else begin
            issue      = 1'b1;
            stall_MEM  = 1'b1;
            state_next = BUSY;
            cnt_next   = 8'd0;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          abort      = 1'b1;
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else begin
          stall_MEM = 1'b1;
          cnt_next  = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    // The upstream stages are never frozen while reset is asserted.
    if (!reset) stall_MEM = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= 64'd0;
      mem_be           <= 8'd0;
      fault_MEM        <= 1'b0;
      RegWrite_WB      <= 1'b0;
      MemtoReg_WB      <= 1'b0;
      Rd_WB            <= 5'd0;
      read_data_WB     <= 64'd0;
      alu_result_WB    <= '0;
      cap_regwrite_reg <= 1'b0;
      cap_memtoreg_reg <= 1'b0;
      cap_write_reg    <= 1'b0;
      cap_byte_reg     <= 1'b0;
      cap_lane_reg     <= 3'd0;
      cap_rd_reg       <= 5'd0;
      cap_alu_reg      <= '0;
    end else begin
      fault_MEM <= bad | abort;
      if (issue) begin
        mem_req          <= 1'b1;
        mem_we           <= MemWrite_MEM;
        mem_addr         <= {address_MEM[ADDR_W-1:3], 3'b000};
        mem_wdata        <= ByteOp_MEM ? wdata_byte : Rd2_Reg_out_MEM;
        mem_be           <= ByteOp_MEM ? (8'd1 << lane) : 8'hFF;
        cap_regwrite_reg <= RegWrite_MEM;
        cap_memtoreg_reg <= MemtoReg_MEM;
        cap_write_reg    <= MemWrite_MEM;
        cap_byte_reg     <= ByteOp_MEM;
        cap_lane_reg     <= lane;
        cap_rd_reg       <= Rd_MEM;
        cap_alu_reg      <= address_MEM;
        // Bubble into WB. The other WB fields keep their previous values.
        RegWrite_WB      <= 1'b0;
      end else if (complete || abort) begin
        // Request fields stay as they are; only mem_req drops.
        mem_req       <= 1'b0;
        RegWrite_WB   <= complete & cap_regwrite_reg;
        MemtoReg_WB   <= cap_memtoreg_reg;
        Rd_WB         <= cap_rd_reg;
        alu_result_WB <= cap_alu_reg;
        read_data_WB  <= (complete && !cap_write_reg) ? read_ext : 64'd0;
      end else if (state_reg == BUSY) begin
        RegWrite_WB <= 1'b0;
      end else begin
        // Plain pass-through. A rejected misaligned access must not write back.
        RegWrite_WB   <= RegWrite_MEM & !bad;
        MemtoReg_WB   <= MemtoReg_MEM;
        Rd_WB         <= Rd_MEM;
        alu_result_WB <= address_MEM;
        read_data_WB  <= 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
module tb_mem_stage_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] address_MEM;
  logic [63:0] Rd2_Reg_out_MEM;
  logic        MemRead_MEM;
  logic        MemWrite_MEM;
  logic        ByteOp_MEM;
  logic        RegWrite_MEM;
  logic        MemtoReg_MEM;
  logic [4:0]  Rd_MEM;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic        stall_MEM;
  logic        fault_MEM;
  logic        RegWrite_WB;
  logic        MemtoReg_WB;
  logic [4:0]  Rd_WB;
  logic [63:0] read_data_WB;
  logic [63:0] alu_result_WB;

  int n_checks = 0;
  int n_fails  = 0;

  mem_stage_access_unit #(.TIMEOUT(4), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset),
    .address_MEM(address_MEM), .Rd2_Reg_out_MEM(Rd2_Reg_out_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .ByteOp_MEM(ByteOp_MEM), .RegWrite_MEM(RegWrite_MEM),
    .MemtoReg_MEM(MemtoReg_MEM), .Rd_MEM(Rd_MEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_MEM(stall_MEM), .fault_MEM(fault_MEM),
    .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB), .Rd_WB(Rd_WB),
    .read_data_WB(read_data_WB), .alu_result_WB(alu_result_WB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic bo,
                        input logic [63:0] addr, input logic [63:0] d2,
                        input logic rw, input logic m2r, input logic [4:0] rdst);
    MemRead_MEM     = rd;
    MemWrite_MEM    = wr;
    ByteOp_MEM      = bo;
    address_MEM     = addr;
    Rd2_Reg_out_MEM = d2;
    RegWrite_MEM    = rw;
    MemtoReg_MEM    = m2r;
    Rd_MEM          = rdst;
  endtask

  // Runs one aligned access whose operands are already driven: the IDLE
  // cycle, wait_n BUSY cycles without mem_ready, then one cycle with
  // mem_ready. Returns the number of stalled cycles and a snapshot of
  // the request taken in the first BUSY cycle.
  task automatic run_access(input int wait_n, input logic [63:0] rdata,
                            output int stalls, output logic req_s, output logic we_s,
                            output logic [63:0] addr_s, output logic [63:0] wdata_s,
                            output logic [7:0] be_s, output logic rw_s);
    stalls = 0;
    #1;
    if (stall_MEM) stalls++;
    tick();
    req_s   = mem_req;
    we_s    = mem_we;
    addr_s  = mem_addr;
    wdata_s = mem_wdata;
    be_s    = mem_be;
    rw_s    = RegWrite_WB;
    for (int i = 0; i < wait_n; i++) begin
      if (stall_MEM) stalls++;
      tick();
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    #1;
    if (stall_MEM) stalls++;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 64'd0;
  endtask

  initial begin
    int          stalls;
    int          req_cycles;
    logic        last_stall;
    logic        req_s, we_s, rw_s;
    logic [63:0] addr_s, wdata_s;
    logic [7:0]  be_s;

    reset     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 64'd0;
    set_op(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 5'd0);

    // Reset held for three cycles with a load present.
    repeat (3) tick();
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall_MEM, 0);
    chk("rst_regwrite_wb", RegWrite_WB, 0);
    chk("rst_memtoreg_wb", MemtoReg_WB, 0);
    chk("rst_rd_wb", Rd_WB, 0);
    chk("rst_rdata_wb", read_data_WB, 0);
    chk("rst_alu_wb", alu_result_WB, 0);
    chk("rst_fault", fault_MEM, 0);
    $display("txn reset: req=%0d stall=%0d", mem_req, stall_MEM);

    reset = 1'b1;
    #1;
    chk("post_rst_stall", stall_MEM, 1);
    chk("post_rst_req_before", mem_req, 0);
    tick();
    chk("post_rst_req", mem_req, 1);
    mem_ready = 1'b1;
    mem_rdata = 64'h1111;
    #1;
    chk("post_rst_ready_stall", stall_MEM, 0);
    tick();
    mem_ready = 1'b0;
    chk("post_rst_req_drop", mem_req, 0);
    $display("txn first access after reset: req=%0d", mem_req);

    // Non-memory op passes straight through.
    set_op(1'b0, 1'b0, 1'b0, 64'h2A, 64'h0, 1'b1, 1'b0, 5'd5);
    #1;
    chk("nop_stall", stall_MEM, 0);
    tick();
    chk("nop_alu_wb", alu_result_WB, 64'h2A);
    chk("nop_rd_wb", Rd_WB, 5);
    chk("nop_regwrite_wb", RegWrite_WB, 1);
    chk("nop_rdata_wb", read_data_WB, 0);
    chk("nop_req", mem_req, 0);
    $display("txn nop: alu_wb=%h rd_wb=%0d", alu_result_WB, Rd_WB);

    // Doubleword load at 0x100, memory answers after three waiting cycles.
    set_op(1'b1, 1'b0, 1'b0, 64'h100, 64'h0, 1'b1, 1'b1, 5'd9);
    run_access(3, 64'hDEADBEEF_CAFEF00D, stalls, req_s, we_s, addr_s, wdata_s, be_s, rw_s);
    chk("ld_req", req_s, 1);
    chk("ld_we", we_s, 0);
    chk("ld_addr", addr_s, 64'h100);
    chk("ld_be", be_s, 8'hFF);
    chk("ld_bubble_regwrite", rw_s, 0);
    chk("ld_stalls", stalls, 4);
    chk("ld_rdata_wb", read_data_WB, 64'hDEADBEEF_CAFEF00D);
    chk("ld_regwrite_wb", RegWrite_WB, 1);
    chk("ld_rd_wb", Rd_WB, 9);
    chk("ld_alu_wb", alu_result_WB, 64'h100);
    chk("ld_req_drop", mem_req, 0);
    $display("txn ld64 @100: rdata_wb=%h stalls=%0d", read_data_WB, stalls);

    // Byte store at 0x103.
    set_op(1'b0, 1'b1, 1'b1, 64'h103, 64'h01234567_89ABCDA5, 1'b0, 1'b0, 5'd0);
    run_access(1, 64'hFFFF_FFFF_FFFF_FFFF, stalls, req_s, we_s, addr_s, wdata_s, be_s, rw_s);
    chk("stb_be", be_s, 8'h08);
    chk("stb_we", we_s, 1);
    chk("stb_addr", addr_s, 64'h100);
    chk("stb_wdata", wdata_s, 64'hA5A5A5A5_A5A5A5A5);
    chk("stb_stalls", stalls, 2);
    chk("stb_rdata_wb", read_data_WB, 0);
    $display("txn stb @103: be=%h wdata=%h", be_s, wdata_s);

    // Byte load at 0x106, lane 6 holds 0x7E.
    set_op(1'b1, 1'b0, 1'b1, 64'h106, 64'h0, 1'b1, 1'b1, 5'd3);
    run_access(0, 64'h117E3344_55667788, stalls, req_s, we_s, addr_s, wdata_s, be_s, rw_s);
    chk("ldb_be", be_s, 8'h40);
    chk("ldb_addr", addr_s, 64'h100);
    chk("ldb_rdata_wb", read_data_WB, 64'h7E);
    chk("ldb_rd_wb", Rd_WB, 3);
    chk("ldb_stalls", stalls, 1);
    $display("txn ldb @106: rdata_wb=%h", read_data_WB);

    // Misaligned doubleword load at 0x104.
    set_op(1'b1, 1'b0, 1'b0, 64'h104, 64'h0, 1'b1, 1'b1, 5'd7);
    #1;
    chk("mis_stall", stall_MEM, 0);
    tick();
    chk("mis_req", mem_req, 0);
    chk("mis_fault", fault_MEM, 1);
    chk("mis_regwrite_wb", RegWrite_WB, 0);
    chk("mis_rd_wb", Rd_WB, 7);
    set_op(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 5'd0);
    tick();
    chk("mis_fault_pulse", fault_MEM, 0);
    $display("txn ld64 misaligned @104: fault seen");

    // Timeout on a store with mem_ready held low.
    set_op(1'b0, 1'b1, 1'b0, 64'h200, 64'h55, 1'b1, 1'b0, 5'd2);
    #1;
    chk("to_idle_stall", stall_MEM, 1);
    tick();
    req_cycles = 0;
    last_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!mem_req) break;
      req_cycles++;
      last_stall = stall_MEM;
      tick();
    end
    chk("to_req_cycles", req_cycles, 4);
    chk("to_last_stall", last_stall, 0);
    chk("to_req_drop", mem_req, 0);
    chk("to_fault", fault_MEM, 1);
    chk("to_regwrite_wb", RegWrite_WB, 0);
    set_op(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 5'd0);
    tick();
    chk("to_fault_pulse", fault_MEM, 0);
    $display("txn st64 timeout @200: req_cycles=%0d", req_cycles);

    // Reset in the middle of a load; a late mem_ready must be ignored.
    set_op(1'b1, 1'b0, 1'b0, 64'h300, 64'h0, 1'b1, 1'b1, 5'd4);
    tick();
    chk("mid_req", mem_req, 1);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", stall_MEM, 0);
    tick();
    chk("mid_rst_req", mem_req, 0);
    set_op(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 5'd0);
    mem_ready = 1'b1;
    mem_rdata = 64'hABCD_ABCD_ABCD_ABCD;
    tick();
    mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk("late_req", mem_req, 0);
    chk("late_regwrite_wb", RegWrite_WB, 0);
    chk("late_rd_wb", Rd_WB, 0);
    chk("late_rdata_wb", read_data_WB, 0);
    chk("late_fault", fault_MEM, 0);
    $display("txn reset mid-busy: req=%0d rdata_wb=%h", mem_req, read_data_WB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
